// File: rtl/sound_io_board_if.sv
// Bus bundle for sound_io_board: host command port, sound CPU register port and audio outputs.
// The master side drives commands and CPU accesses; the slave side is the board logic.
interface sound_io_board_if #(
  parameter int unsigned NUM_DAC   = 2,
  parameter int unsigned CMD_WIDTH = 6
);
  localparam int unsigned AUD_W = 8 + $clog2(NUM_DAC);

  logic                   cmd_wr;
  logic [CMD_WIDTH-1:0]   cmd_data;
  logic                   cmd_full;
  logic                   cpu_cs;
  logic                   cpu_we;
  logic [3:0]             cpu_addr;
  logic [7:0]             cpu_din;
  logic [7:0]             cpu_dout;
  logic                   irq_n;
  logic [8*NUM_DAC-1:0]   dac_out;
  logic [AUD_W-1:0]       audio_out;

  modport master (
    output cmd_wr, cmd_data, cpu_cs, cpu_we, cpu_addr, cpu_din,
    input  cmd_full, cpu_dout, irq_n, dac_out, audio_out
  );

  modport slave (
    input  cmd_wr, cmd_data, cpu_cs, cpu_we, cpu_addr, cpu_din,
    output cmd_full, cpu_dout, irq_n, dac_out, audio_out
  );
endinterface

// File: rtl/sound_io_board.sv
// Sound board I/O: buffered host commands with CPU IRQ, NUM_DAC latched DAC channels and summed audio.
// Optional DAC slew limiting is built when the macro SOUND_IO_SLEW_EN is defined.
module sound_io_board #(
  parameter int unsigned NUM_DAC   = 2,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned CMD_WIDTH = 6,
  parameter int unsigned SLEW_DIV  = 16
) (
  input  logic            clk,
  input  logic            reset,
  sound_io_board_if.slave bus
);
  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned AUD_W = 8 + $clog2(NUM_DAC);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);
  localparam logic [7:0]       DAC_MID = 8'h80;

  logic [CMD_WIDTH-1:0] mem_q [CMD_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_c;
  logic                 full_q;
  logic                 ovf_q;
  logic                 irq_en_q;
  logic                 irq_n_q;
  logic [7:0]           dout_q;
  logic [7:0]           dout_c;
  logic [7:0]           latch_q [NUM_DAC];
  logic [7:0]           dac_q   [NUM_DAC];
  logic [AUD_W-1:0]     audio_q;
  logic [AUD_W-1:0]     sum_c;

  logic rd_c, wr_c, ctrl_wr_c, stat_rd_c, flush_c, pop_c, push_c, drop_c, empty_c;

  // Access decode and FIFO occupancy update
  always_comb begin
    rd_c      = bus.cpu_cs & ~bus.cpu_we;
    wr_c      = bus.cpu_cs & bus.cpu_we;
    empty_c   = (count_q == '0);
    ctrl_wr_c = wr_c && (bus.cpu_addr == 4'd1);
    stat_rd_c = rd_c && (bus.cpu_addr == 4'd1);
    flush_c   = ctrl_wr_c && bus.cpu_din[1];
    pop_c     = rd_c && (bus.cpu_addr == 4'd0) && !empty_c;
    push_c    = bus.cmd_wr && !flush_c && ((count_q < DEPTH_C) || pop_c);
    drop_c    = bus.cmd_wr && !flush_c && !push_c;
    count_c   = count_q;
    if (flush_c) begin
      count_c = '0;
    end else if (push_c && !pop_c) begin
      count_c = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_c = count_q - CNT_W'(1);
    end
  end

  // Read data mux; holds the previous value when no read occurs
  always_comb begin
    dout_c = dout_q;
    if (rd_c) begin
      case (bus.cpu_addr)
        4'd0:    dout_c = pop_c ? 8'(mem_q[rd_ptr_q]) : 8'h00;
        4'd1:    dout_c = {ovf_q, full_q, empty_c, irq_en_q, count_q};
        default: dout_c = 8'h00;
      endcase
    end
  end

  // Command FIFO control, status and IRQ
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b1;
      irq_n_q  <= 1'b1;
      dout_q   <= 8'h00;
    end else begin
      count_q <= count_c;
      full_q  <= (count_c == DEPTH_C);
      dout_q  <= dout_c;
      irq_n_q <= ~(irq_en_q & ~empty_c);
      if (flush_c) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      // A drop in the same cycle as a status read wins over the clear
      if (drop_c) begin
        ovf_q <= 1'b1;
      end else if (stat_rd_c) begin
        ovf_q <= 1'b0;
      end
      if (ctrl_wr_c) irq_en_q <= bus.cpu_din[0];
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.cmd_data;
  end

  // DAC latches at addresses 2..NUM_DAC+1
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DAC; k++) latch_q[k] <= DAC_MID;
    end else begin
      for (int k = 0; k < NUM_DAC; k++) begin
        if (wr_c && (bus.cpu_addr == 4'(k + 2))) latch_q[k] <= bus.cpu_din;
      end
    end
  end

`ifdef SOUND_IO_SLEW_EN
  localparam int unsigned DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             tick_c;

  assign tick_c = (div_q == DIV_W'(SLEW_DIV - 1));

  // Free-running slew divider, independent of latch writes
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= tick_c ? '0 : div_q + DIV_W'(1);
    end
  end

  // Each channel walks one LSB per tick toward its latch
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DAC; k++) dac_q[k] <= DAC_MID;
    end else if (tick_c) begin
      for (int k = 0; k < NUM_DAC; k++) begin
        if (dac_q[k] < latch_q[k]) begin
          dac_q[k] <= dac_q[k] + 8'd1;
        end else if (dac_q[k] > latch_q[k]) begin
          dac_q[k] <= dac_q[k] - 8'd1;
        end
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_DAC; k++) dac_q[k] = latch_q[k];
  end
`endif

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_DAC; k++) sum_c = sum_c + AUD_W'(dac_q[k]);
  end

  // Audio is the sum of the channel outputs, one register stage behind them
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_q <= '0;
    end else begin
      audio_q <= sum_c;
    end
  end

  for (genvar g = 0; g < NUM_DAC; g++) begin : g_dac
    assign bus.dac_out[8*g +: 8] = dac_q[g];
  end

  assign bus.cmd_full  = full_q;
  assign bus.cpu_dout  = dout_q;
  assign bus.irq_n     = irq_n_q;
  assign bus.audio_out = audio_q;
endmodule
